optic_rx_multi: RTL and testbench
=================================

// Module: optic_rx_multi
// PURPOSE
//  Parametrised successor receiver for the LC optic serial link, clk_rx domain (250 MHz).
//  Decodes oversampled NRZ frames of NUM_BYTES payload bytes plus one check byte.
//  Frame layout: low gap, header '1' bit, payload MSB-first, check byte, long-high tail.
//  Adds a valid strobe, multi-byte payload, XOR checksum, timeout error flag and a saturating error counter.
//  Sits between the optic PHY pin and the user register/command logic.
// PARAMETERS
//  CLKS_PER_BIT   5     clk_rx cycles per line bit (>=4)
//  NUM_BYTES      2     payload bytes per frame (1..16)
//  SYNC_CLKS      31    quiet-line cycles that qualify a frame start (low) or frame end (high)
//  COMM_ERR_CLKS  63    cycles without any line edge before rx_comm_err sets
//  TIMEOUT_CLKS   2048  max cycles from header to frame end before abort
//  ERR_CNT_W      16    width of rx_err_cnt
// PORTS
//  clk_rx         in   1              receive clock
//  reset          in   1              asynchronous, active-high reset
//  phy_rxd        in   1              serial line, asynchronous to clk_rx
//  rxd_data       out  8*NUM_BYTES    last good payload; byte0 (first received) in MSBs
//  rxd_valid      out  1              1-cycle pulse when rxd_data updates
//  rx_comm_err    out  1              1 = no line edge for COMM_ERR_CLKS cycles
//  rx_verify_err  out  1              1 = last completed frame failed its check byte
//  rx_timeout_err out  1              1-cycle pulse on frame abort by timeout
//  rx_err_cnt     out  ERR_CNT_W      saturating count of verify failures + timeouts
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all counters 0 (quiet counter 0, so SYNC_CLKS quiet needed after reset).
//  Input path:
//  - phy_rxd passes through a 2-flop synchroniser, then one more register.
//  - edge = synced level != delayed level; all logic uses the synced level.
//  quiet_cnt: cleared on edge, else increments, saturates at max.
//  rx_comm_err: set when quiet_cnt >= COMM_ERR_CLKS; cleared on next edge.
//  Bit timing:
//  - bit_clk_cnt runs 1..CLKS_PER_BIT; forced to 1 on any edge or on wrap.
//  - MID = CLKS_PER_BIT/2+1; the bit is sampled when bit_clk_cnt==MID.
//  - Bit advance: bit_clk_cnt==CLKS_PER_BIT, or an edge while bit_clk_cnt>=MID (early edge).
//  - An edge with bit_clk_cnt<MID only realigns and never advances twice.
//  FSM (one-hot):
//  - IDLE: go to HEADER on rising edge with quiet_cnt>=SYNC_CLKS (line low). Other edges ignored.
//  - HEADER: go to DATA on falling edge, or after CLKS_PER_BIT high cycles (first data bit is 1).
//  - DATA: shift 8*NUM_BYTES bits MSB-first; go to CHECK after the last bit advances.
//  - CHECK: shift 8 bits; go to TAIL after the 8th bit advances.
//  - TAIL: go to IDLE when line high and quiet_cnt>=SYNC_CLKS.
//  Check byte = ~(XOR of all payload bytes); for NUM_BYTES=1 this is ~data.
//  Frame end (TAIL->IDLE):
//  - Check OK: rxd_data <= shift reg, rxd_valid=1 for that cycle, rx_verify_err<=0.
//  - Check bad: rxd_data held, rx_verify_err<=1, rx_err_cnt+1.
//  rx_verify_err holds its value until the next frame end.
//  Timeout:
//  - Counter runs in any non-IDLE state; clears in IDLE.
//  - On reaching TIMEOUT_CLKS (any state): go to IDLE, pulse rx_timeout_err, rx_err_cnt+1, rxd_data held.
//  - Timeout has priority over normal transitions in the same cycle.
//  rx_err_cnt saturates at all-ones; a verify failure and a timeout never coincide (exclusive states).
//  Reset mid-frame: returns to reset values; the partial frame is discarded without a count.
//  Latency: rxd_valid fires SYNC_CLKS+3..4 cycles after the tail's rising edge at phy_rxd.
// TESTING (CLKS_PER_BIT=5, NUM_BYTES=2)
//  1. Frame A5,3C, check 66 -> rxd_valid 1 pulse, rxd_data=16'hA53C, rx_verify_err=0, rx_err_cnt=0.
//  2. Same frame with check 67 -> no rxd_valid, rxd_data unchanged, rx_verify_err=1, rx_err_cnt=1.
//  3. Frame 00,FF, every edge jittered +-1 clk -> rxd_data=16'h00FF, single rxd_valid.
//  4. Header then line stuck low -> rx_comm_err=1 after 63 quiet clks; at 2048 clks IDLE, rx_timeout_err pulse, rx_err_cnt+1.
//  5. Reset asserted mid-DATA -> outputs 0.
//     Header after only 20 low clks is ignored; next qualified frame 12,34 (check D9) -> rxd_data=16'h1234.
//  6. ERR_CNT_W=2, four bad-check frames -> rx_err_cnt=3 (saturated), rx_verify_err=1.

Source files
------------

// File: rtl/optic_rx_multi_if.sv
// Signal bundle between the optic PHY pin and the receiver's decoded outputs.
// The master modport is the receiver side; the slave modport is the PHY/consumer side.
interface optic_rx_multi_if #(
  parameter int NUM_BYTES = 2,
  parameter int ERR_CNT_W = 16
);
  logic                   phy_rxd;
  logic [8*NUM_BYTES-1:0] rxd_data;
  logic                   rxd_valid;
  logic                   rx_comm_err;
  logic                   rx_verify_err;
  logic                   rx_timeout_err;
  logic [ERR_CNT_W-1:0]   rx_err_cnt;

  modport master (
    input  phy_rxd,
    output rxd_data, rxd_valid, rx_comm_err, rx_verify_err, rx_timeout_err, rx_err_cnt
  );

  modport slave (
    output phy_rxd,
    input  rxd_data, rxd_valid, rx_comm_err, rx_verify_err, rx_timeout_err, rx_err_cnt
  );
endinterface

// File: rtl/optic_rx_multi.sv
// Oversampled NRZ frame receiver for the LC optic link: header bit, NUM_BYTES payload,
// inverted-XOR check byte, long-high tail; reports good payloads and error status.
module optic_rx_multi #(
  parameter int CLKS_PER_BIT  = 5,
  parameter int NUM_BYTES     = 2,
  parameter int SYNC_CLKS     = 31,
  parameter int COMM_ERR_CLKS = 63,
  parameter int TIMEOUT_CLKS  = 2048,
  parameter int ERR_CNT_W     = 16
) (
  input  logic             clk_rx,
  input  logic             reset,
  optic_rx_multi_if.master rx
);

  localparam int DATA_W    = 8 * NUM_BYTES;
  localparam int QUIET_MAX = (COMM_ERR_CLKS > SYNC_CLKS) ? COMM_ERR_CLKS : SYNC_CLKS;
  localparam int QW        = $clog2(QUIET_MAX + 1);
  localparam int BW        = $clog2(CLKS_PER_BIT + 1);
  localparam int NW        = $clog2(DATA_W + 1);
  localparam int TW        = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [QW-1:0]        SYNC_Q    = QW'(SYNC_CLKS);
  localparam logic [QW-1:0]        COMM_Q    = QW'(COMM_ERR_CLKS);
  localparam logic [QW-1:0]        QUIET_SAT = '1;
  localparam logic [BW-1:0]        BIT_MID   = BW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [BW-1:0]        BIT_LAST  = BW'(CLKS_PER_BIT);
  localparam logic [NW-1:0]        DATA_LAST = NW'(DATA_W - 1);
  localparam logic [NW-1:0]        CHK_LAST  = NW'(7);
  localparam logic [TW-1:0]        TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

  localparam logic [4:0] S_IDLE   = 5'b00001;
  localparam logic [4:0] S_HEADER = 5'b00010;
  localparam logic [4:0] S_DATA   = 5'b00100;
  localparam logic [4:0] S_CHECK  = 5'b01000;
  localparam logic [4:0] S_TAIL   = 5'b10000;

  logic              sync1, line, line_d;
  logic              line_edge;
  logic [QW-1:0]     quiet_cnt;
  logic [BW-1:0]     bit_clk_cnt;
  logic              bit_val;
  logic              bit_adv;
  logic [4:0]        state;
  logic [NW-1:0]     bit_idx;
  logic [DATA_W-1:0] data_sr;
  logic [7:0]        check_sr;
  logic [TW-1:0]     tmo_cnt;
  logic              timeout;
  logic              frame_end;
  logic              check_ok;
  logic [7:0]        xor_acc;

  assign line_edge = line ^ line_d;
  // An edge at or past mid-bit closes the current bit early; earlier edges only realign.
  assign bit_adv   = (bit_clk_cnt == BIT_LAST) || (line_edge && (bit_clk_cnt >= BIT_MID));
  assign timeout   = (state != S_IDLE) && (tmo_cnt == TMO_LAST);
  assign frame_end = (state == S_TAIL) && line && (quiet_cnt >= SYNC_Q);

  always_comb begin
    xor_acc = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      xor_acc = xor_acc ^ data_sr[8*i +: 8];
    end
  end

  assign check_ok = (check_sr == ~xor_acc);

  always_ff @(posedge clk_rx or posedge reset) begin
    if (reset) begin
      sync1          <= 1'b0;
      line           <= 1'b0;
      line_d         <= 1'b0;
      quiet_cnt      <= '0;
      rx.rx_comm_err <= 1'b0;
    end else begin
      sync1  <= rx.phy_rxd;
      line   <= sync1;
      line_d <= line;
      if (line_edge) begin
        quiet_cnt <= '0;
      end else if (quiet_cnt != QUIET_SAT) begin
        quiet_cnt <= quiet_cnt + 1'b1;
      end
      if (line_edge) begin
        rx.rx_comm_err <= 1'b0;
      end else if (quiet_cnt >= COMM_Q) begin
        rx.rx_comm_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_rx or posedge reset) begin
    if (reset) begin
      bit_clk_cnt <= '0;
      bit_val     <= 1'b0;
    end else begin
      if (line_edge || (bit_clk_cnt == BIT_LAST)) begin
        bit_clk_cnt <= BW'(1);
      end else begin
        bit_clk_cnt <= bit_clk_cnt + 1'b1;
      end
      if (bit_clk_cnt == BIT_MID) begin
        bit_val <= line;
      end
    end
  end

  // Timeout wins over every normal transition, so a stuck frame always returns to IDLE.
  always_ff @(posedge clk_rx or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      bit_idx           <= '0;
      data_sr           <= '0;
      check_sr          <= '0;
      tmo_cnt           <= '0;
      rx.rxd_data       <= '0;
      rx.rxd_valid      <= 1'b0;
      rx.rx_verify_err  <= 1'b0;
      rx.rx_timeout_err <= 1'b0;
      rx.rx_err_cnt     <= '0;
    end else begin
      rx.rxd_valid      <= 1'b0;
      rx.rx_timeout_err <= 1'b0;
      if (state == S_IDLE) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (timeout) begin
        state             <= S_IDLE;
        rx.rx_timeout_err <= 1'b1;
        if (rx.rx_err_cnt != ERR_MAX) begin
          rx.rx_err_cnt <= rx.rx_err_cnt + 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (line_edge && line && (quiet_cnt >= SYNC_Q)) begin
              state <= S_HEADER;
            end
          end
          S_HEADER: begin
            if (line_edge || (bit_clk_cnt == BIT_LAST)) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end
          S_DATA: begin
            if (bit_adv) begin
              data_sr <= {data_sr[DATA_W-2:0], bit_val};
              if (bit_idx == DATA_LAST) begin
                state   <= S_CHECK;
                bit_idx <= '0;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
          S_CHECK: begin
            if (bit_adv) begin
              check_sr <= {check_sr[6:0], bit_val};
              if (bit_idx == CHK_LAST) begin
                state <= S_TAIL;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
          S_TAIL: begin
            if (frame_end) begin
              state <= S_IDLE;
              if (check_ok) begin
                rx.rxd_data      <= data_sr;
                rx.rxd_valid     <= 1'b1;
                rx.rx_verify_err <= 1'b0;
              end else begin
                rx.rx_verify_err <= 1'b1;
                if (rx.rx_err_cnt != ERR_MAX) begin
                  rx.rx_err_cnt <= rx.rx_err_cnt + 1'b1;
                end
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_optic_rx_multi.sv
// Self-checking bench for optic_rx_multi: frames are built bit by bit and compared
// against a transaction-level model of payload, check byte and error bookkeeping.
module tb_optic_rx_multi;

  localparam int CPB   = 5;
  localparam int NBITS = 26;
  localparam int TAIL  = 60;

  logic clk_rx = 1'b0;
  logic reset  = 1'b0;

  always #2 clk_rx = ~clk_rx;

  optic_rx_multi_if #(.NUM_BYTES(2), .ERR_CNT_W(16)) bus ();
  optic_rx_multi_if #(.NUM_BYTES(2), .ERR_CNT_W(2))  bus_sat ();

  assign bus_sat.phy_rxd = bus.phy_rxd;

  optic_rx_multi #(
    .CLKS_PER_BIT(5), .NUM_BYTES(2), .SYNC_CLKS(31),
    .COMM_ERR_CLKS(63), .TIMEOUT_CLKS(2048), .ERR_CNT_W(16)
  ) dut (
    .clk_rx(clk_rx), .reset(reset), .rx(bus)
  );

  optic_rx_multi #(
    .CLKS_PER_BIT(5), .NUM_BYTES(2), .SYNC_CLKS(31),
    .COMM_ERR_CLKS(63), .TIMEOUT_CLKS(2048), .ERR_CNT_W(2)
  ) dut_sat (
    .clk_rx(clk_rx), .reset(reset), .rx(bus_sat)
  );

  int          total = 0;
  int          bad   = 0;
  logic [15:0] model_data = '0;
  logic        model_verify = 1'b0;
  int          model_errs = 0;
  logic [15:0] exp_q[$];
  bit          expect_timeout = 1'b0;
  int          since_edge = 0;
  logic        prev_phy = 1'b1;
  logic [15:0] exp_word;

  function automatic logic [7:0] calcCheck(input logic [15:0] p);
    return ~(p[15:8] ^ p[7:0]);
  endfunction

  function automatic int satErrs(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_rx);
    #1;
  endtask

  // Every cycle: valid strobes must match queued good frames, data must hold otherwise.
  always @(negedge clk_rx) begin
    if (reset) begin
      since_edge = 0;
      prev_phy   = bus.phy_rxd;
    end else begin
      if (bus.phy_rxd !== prev_phy) since_edge = 0;
      else since_edge++;
      prev_phy = bus.phy_rxd;
      if (bus.rxd_valid) begin
        checkOutput("valid_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_word = exp_q.pop_front();
          checkOutput("valid_data", 32'(bus.rxd_data), 32'(exp_word));
          model_data   = exp_word;
          model_verify = 1'b0;
        end
      end else begin
        checkOutput("data_hold", 32'(bus.rxd_data), 32'(model_data));
      end
      if (!expect_timeout) checkOutput("no_timeout", 32'(bus.rx_timeout_err), 32'd0);
      if (since_edge >= 4 && since_edge <= 60) checkOutput("comm_err_clear", 32'(bus.rx_comm_err), 32'd0);
      else if (since_edge >= 70) checkOutput("comm_err_set", 32'(bus.rx_comm_err), 32'd1);
    end
  end

  task automatic frameChecks(input string tag);
    checkOutput({tag, "_missed_valid"}, 32'(exp_q.size()), 32'd0);
    checkOutput({tag, "_data"}, 32'(bus.rxd_data), 32'(model_data));
    checkOutput({tag, "_verify"}, 32'(bus.rx_verify_err), 32'(model_verify));
    checkOutput({tag, "_errcnt"}, 32'(bus.rx_err_cnt), 32'(model_errs));
    checkOutput({tag, "_errcnt_sat"}, 32'(bus_sat.rx_err_cnt), 32'(satErrs(model_errs)));
  endtask

  task automatic doReset(input bit check_zero);
    reset        = 1'b1;
    bus.phy_rxd  = 1'b1;
    model_data   = '0;
    model_verify = 1'b0;
    model_errs   = 0;
    exp_q.delete();
    repeat (3) tick;
    if (check_zero) begin
      checkOutput("rst_data", 32'(bus.rxd_data), 32'd0);
      checkOutput("rst_valid", 32'(bus.rxd_valid), 32'd0);
      checkOutput("rst_comm", 32'(bus.rx_comm_err), 32'd0);
      checkOutput("rst_verify", 32'(bus.rx_verify_err), 32'd0);
      checkOutput("rst_timeout", 32'(bus.rx_timeout_err), 32'd0);
      checkOutput("rst_errcnt", 32'(bus.rx_err_cnt), 32'd0);
    end
    reset = 1'b0;
    repeat (60) tick;
  endtask

  // Drives low gap, header, payload, check byte and tail; abort_at>0 stops mid-frame.
  task automatic applyStimulus(input logic [15:0] payload, input logic [7:0] chk, input bit jitter,
                               input int gap, input int abort_at, input string tag);
    logic [NBITS-1:0] bits;
    int   edges[$];
    int   prev_off, off, ei;
    logic level;
    bit   good;
    bits     = {1'b1, payload, chk, 1'b1};
    good     = (chk == calcCheck(payload));
    prev_off = 0;
    edges.push_back(0);
    for (int k = 1; k < NBITS; k++) begin
      if (bits[NBITS-1-k] != bits[NBITS-k]) begin
        off = jitter ? int'($urandom_range(2)) - 1 : 0;
        if (prev_off == 1 && off == -1) off = 0;
        edges.push_back(CPB * k + off);
        prev_off = off;
      end
    end
    bus.phy_rxd = 1'b0;
    repeat (gap) tick;
    level = 1'b0;
    ei    = 0;
    for (int t = 0; t <= CPB * (NBITS - 1) + TAIL; t++) begin
      if (ei < edges.size() && edges[ei] == t) begin
        level = ~level;
        ei++;
      end
      bus.phy_rxd = level;
      if (t == CPB * (NBITS - 1) && good) exp_q.push_back(payload);
      if (abort_at > 0 && t == abort_at) return;
      tick;
    end
    if (!good) begin
      model_verify = 1'b1;
      model_errs++;
    end
    frameChecks(tag);
  endtask

  task automatic stuckLowTest;
    int n;
    bit seen;
    bus.phy_rxd = 1'b0;
    repeat (40) tick;
    bus.phy_rxd = 1'b1;
    repeat (CPB) tick;
    bus.phy_rxd    = 1'b0;
    expect_timeout = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 2300) begin
      tick;
      n++;
      if (bus.rx_timeout_err) seen = 1'b1;
    end
    checkOutput("T4_timeout_seen", 32'(seen), 32'd1);
    checkOutput("T4_timeout_window", 32'(n >= 2030 && n <= 2070), 32'd1);
    checkOutput("T4_comm_err", 32'(bus.rx_comm_err), 32'd1);
    tick;
    checkOutput("T4_timeout_pulse_width", 32'(bus.rx_timeout_err), 32'd0);
    expect_timeout = 1'b0;
    model_errs++;
    frameChecks("T4");
  endtask

  initial begin
    logic [15:0] p;
    logic [7:0]  c;
    logic [7:0]  flip;
    bus.phy_rxd = 1'b1;
    #1;
    doReset(1'b1);

    checkOutput("model_chk_A53C", 32'(calcCheck(16'hA53C)), 32'h66);
    checkOutput("model_chk_1234", 32'(calcCheck(16'h1234)), 32'hD9);
    checkOutput("model_chk_00FF", 32'(calcCheck(16'h00FF)), 32'h00);

    $display("[TB] T1 good frame A53C");
    applyStimulus(16'hA53C, 8'h66, 1'b0, 40, 0, "T1");
    checkOutput("T1_literal", 32'(bus.rxd_data), 32'hA53C);

    $display("[TB] T2 bad check byte");
    applyStimulus(16'hA53C, 8'h67, 1'b0, 40, 0, "T2");
    checkOutput("T2_literal_data", 32'(bus.rxd_data), 32'hA53C);
    checkOutput("T2_literal_verify", 32'(bus.rx_verify_err), 32'd1);
    checkOutput("T2_literal_errcnt", 32'(bus.rx_err_cnt), 32'd1);

    $display("[TB] T3 jittered frame 00FF");
    applyStimulus(16'h00FF, 8'h00, 1'b1, 40, 0, "T3");
    checkOutput("T3_literal", 32'(bus.rxd_data), 32'h00FF);

    $display("[TB] T4 line stuck low after header");
    stuckLowTest();
    checkOutput("T4_literal_errcnt", 32'(bus.rx_err_cnt), 32'd2);
    doReset(1'b0);

    $display("[TB] random frames");
    for (int i = 0; i < 16; i++) begin
      p = 16'($urandom);
      c = calcCheck(p);
      if ($urandom_range(9) < 3) begin
        flip = 8'h01 << $urandom_range(7);
        c    = c ^ flip;
      end
      applyStimulus(p, c, 1'($urandom_range(1)), 35 + int'($urandom_range(15)), 0, "rand");
    end
    applyStimulus(16'hBEEF, 8'h00, 1'b1, 40, 0, "pre_T5");

    $display("[TB] T5 reset mid-frame, short gap ignored");
    applyStimulus(16'h1234, 8'hD9, 1'b0, 40, 40, "T5_abort");
    doReset(1'b1);
    bus.phy_rxd = 1'b0;
    repeat (20) tick;
    bus.phy_rxd = 1'b1;
    repeat (80) tick;
    applyStimulus(16'h1234, 8'hD9, 1'b0, 40, 0, "T5");
    checkOutput("T5_literal", 32'(bus.rxd_data), 32'h1234);

    $display("[TB] T6 error counter saturation");
    for (int i = 0; i < 4; i++) begin
      p = 16'($urandom);
      applyStimulus(p, calcCheck(p) ^ 8'h01, 1'($urandom_range(1)), 40, 0, "T6");
    end
    checkOutput("T6_literal_sat", 32'(bus_sat.rx_err_cnt), 32'd3);
    checkOutput("T6_literal_main", 32'(bus.rx_err_cnt), 32'd4);
    checkOutput("T6_literal_verify", 32'(bus_sat.rx_verify_err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
